// File: rtl/multi_tick_timer.sv
// Bank of independent tick counters. Each channel has a programmable terminal count
// and mode, and emits a registered timeout pulse. Shared config port and count readback.

module multi_tick_timer_ch #(
    parameter int WIDTH      = 7,
    parameter int TERM_RESET = 99,
    parameter bit MODE_RESET = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_hit,
    input  logic [WIDTH-1:0] cfg_term,
    input  logic             cfg_mode,
    input  logic             clr,
    input  logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             timeout_nx,
    output logic             timeout,
    output logic             done
);
    typedef enum logic {ST_RUN, ST_DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] term, term_nx;
    logic [WIDTH-1:0] count_nx;
    logic             mode, mode_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_RUN;
            count   <= '0;
            term    <= WIDTH'(TERM_RESET);
            mode    <= MODE_RESET;
            timeout <= 1'b0;
        end else begin
            state   <= state_nx;
            count   <= count_nx;
            term    <= term_nx;
            mode    <= mode_nx;
            timeout <= timeout_nx;
        end
    end

    // Config write beats clear, clear beats a tick; the terminal compare runs before
    // the increment so a full-range term never wraps through the adder.
    always_comb begin
        state_nx   = state;
        count_nx   = count;
        term_nx    = term;
        mode_nx    = mode;
        timeout_nx = 1'b0;
        if (cfg_hit) begin
            term_nx  = cfg_term;
            mode_nx  = cfg_mode;
            count_nx = '0;
            state_nx = ST_RUN;
        end else if (clr) begin
            count_nx = '0;
            state_nx = ST_RUN;
        end else if (tick && state == ST_RUN) begin
            if (count == term) begin
                count_nx   = '0;
                timeout_nx = 1'b1;
                if (mode) state_nx = ST_DONE;
            end else begin
                count_nx = count + WIDTH'(1);
            end
        end
    end

    assign done = (state == ST_DONE);
endmodule

module multi_tick_timer #(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 7,
    parameter int TERM_RESET = 99,
    parameter bit MODE_RESET = 1'b0,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] enable,
    input  logic [NUM_CH-1:0] in,
    input  logic [NUM_CH-1:0] ch_clr,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_term,
    input  logic              cfg_mode,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [NUM_CH-1:0] timeout,
    output logic [NUM_CH-1:0] done,
    output logic              any_timeout,
    output logic [WIDTH-1:0]  rd_count
);
    logic [NUM_CH-1:0][WIDTH-1:0] counts;
    logic [NUM_CH-1:0]            cfg_hit;
    logic [NUM_CH-1:0]            timeout_nx;
    logic [WIDTH-1:0]             rd_mux;

    // Out-of-range channel numbers match no channel, so such writes/reads are inert.
    always_comb begin
        cfg_hit = '0;
        rd_mux  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_hit[i] = cfg_we && (int'(cfg_ch) == i);
            if (int'(rd_ch) == i) rd_mux = counts[i];
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        multi_tick_timer_ch #(
            .WIDTH      (WIDTH),
            .TERM_RESET (TERM_RESET),
            .MODE_RESET (MODE_RESET)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .cfg_hit    (cfg_hit[i]),
            .cfg_term   (cfg_term),
            .cfg_mode   (cfg_mode),
            .clr        (ch_clr[i]),
            .tick       (enable[i] & in[i]),
            .count      (counts[i]),
            .timeout_nx (timeout_nx[i]),
            .timeout    (timeout[i]),
            .done       (done[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count    <= '0;
            any_timeout <= 1'b0;
        end else begin
            rd_count    <= rd_mux;
            any_timeout <= |timeout_nx;
        end
    end
endmodule

// File: tb/tb_multi_tick_timer.sv
// Self-checking bench for multi_tick_timer: table-driven one-shot sequence, hand sequences
// for multi-cycle corners, and a per-cycle scoreboard of all outputs.

module tb_multi_tick_timer;
    localparam int NCH = 3;
    localparam int W   = 7;
    localparam int CHW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] enable, in, ch_clr;
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [W-1:0]   cfg_term;
    logic           cfg_mode;
    logic [CHW-1:0] rd_ch;
    logic [NCH-1:0] timeout, done;
    logic           any_timeout;
    logic [W-1:0]   rd_count;

    int checks = 0;
    int errors = 0;

    multi_tick_timer #(.NUM_CH(NCH), .WIDTH(W), .TERM_RESET(99), .MODE_RESET(1'b0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .in(in), .ch_clr(ch_clr),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_term(cfg_term), .cfg_mode(cfg_mode),
        .rd_ch(rd_ch), .timeout(timeout), .done(done), .any_timeout(any_timeout),
        .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] to;
        logic [NCH-1:0] dn;
        logic           any;
        logic [W-1:0]   rdc;
    } exp_t;

    typedef struct {
        logic           rst;
        logic [NCH-1:0] en;
        logic [NCH-1:0] inp;
        logic [NCH-1:0] clr;
        logic           we;
        logic [CHW-1:0] ch;
        logic [W-1:0]   term;
        logic           mode;
        logic [CHW-1:0] rd;
        logic [NCH-1:0] to;
        logic [NCH-1:0] dn;
        logic [W-1:0]   rdc;
    } vec_t;

    exp_t         sb[$];
    logic [W-1:0] m_cnt[NCH];
    logic [W-1:0] m_term[NCH];
    logic         m_mode[NCH];
    logic         m_done[NCH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: predict outputs from the behavioural reference, push, clock, pop, compare.
    task automatic cyc();
        exp_t e;
        e.to  = '0;
        e.rdc = (rd_ch < CHW'(NCH)) ? m_cnt[rd_ch] : '0;
        if (rst) begin
            e.rdc = '0;
            for (int c = 0; c < NCH; c++) begin
                m_cnt[c] = '0; m_term[c] = 7'd99; m_mode[c] = 1'b0; m_done[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (cfg_we && cfg_ch == CHW'(c)) begin
                    m_term[c] = cfg_term; m_mode[c] = cfg_mode; m_cnt[c] = '0; m_done[c] = 1'b0;
                end else if (ch_clr[c]) begin
                    m_cnt[c] = '0; m_done[c] = 1'b0;
                end else if (enable[c] && in[c] && !m_done[c]) begin
                    if (m_cnt[c] == m_term[c]) begin
                        m_cnt[c] = '0; e.to[c] = 1'b1;
                        if (m_mode[c]) m_done[c] = 1'b1;
                    end else begin
                        m_cnt[c] = m_cnt[c] + 7'd1;
                    end
                end
            end
        end
        for (int c = 0; c < NCH; c++) e.dn[c] = m_done[c];
        e.any = |e.to;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_timeout", timeout, e.to);
        chk("sb_done", done, e.dn);
        chk("sb_any_timeout", any_timeout, e.any);
        chk("sb_rd_count", rd_count, e.rdc);
    endtask

    task automatic idle_inputs();
        enable = '0; in = '0; ch_clr = '0; cfg_we = 1'b0; cfg_ch = '0;
        cfg_term = '0; cfg_mode = 1'b0; rd_ch = '0; rst = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    function automatic vec_t v(logic r, logic [2:0] en, logic [2:0] clr, logic we,
                               logic [2:0] to, logic [2:0] dn, logic [6:0] rdc);
        vec_t x;
        x.rst = r; x.en = en; x.inp = en; x.clr = clr; x.we = we; x.ch = 2'd1;
        x.term = 7'd3; x.mode = 1'b1; x.rd = 2'd1; x.to = to; x.dn = dn; x.rdc = rdc;
        return x;
    endfunction

    vec_t tbl[17];

    initial begin
        // ch1 one-shot, term=3: pulse after 4th tick, DONE swallows ticks, ch_clr re-arms.
        tbl[0]  = v(1, 3'b000, 3'b000, 0, 3'b000, 3'b000, 7'd0);
        tbl[1]  = v(0, 3'b010, 3'b000, 1, 3'b000, 3'b000, 7'd0);
        tbl[2]  = v(0, 3'b010, 3'b000, 0, 3'b000, 3'b000, 7'd0);
        tbl[3]  = v(0, 3'b010, 3'b000, 0, 3'b000, 3'b000, 7'd1);
        tbl[4]  = v(0, 3'b010, 3'b000, 0, 3'b000, 3'b000, 7'd2);
        tbl[5]  = v(0, 3'b010, 3'b000, 0, 3'b010, 3'b010, 7'd3);
        for (int i = 6; i < 12; i++) tbl[i] = v(0, 3'b010, 3'b000, 0, 3'b000, 3'b010, 7'd0);
        tbl[12] = v(0, 3'b010, 3'b010, 0, 3'b000, 3'b000, 7'd0);
        tbl[13] = v(0, 3'b010, 3'b000, 0, 3'b000, 3'b000, 7'd0);
        tbl[14] = v(0, 3'b010, 3'b000, 0, 3'b000, 3'b000, 7'd1);
        tbl[15] = v(0, 3'b010, 3'b000, 0, 3'b000, 3'b000, 7'd2);
        tbl[16] = v(0, 3'b010, 3'b000, 0, 3'b010, 3'b010, 7'd3);

        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = '0; m_term[c] = 7'd99; m_mode[c] = 1'b0; m_done[c] = 1'b0;
        end
        idle_inputs();

        // Reset defaults, then auto-reload at the reset terminal count.
        do_reset();
        chk("rst_timeout", timeout, 0);
        chk("rst_done", done, 0);
        chk("rst_any", any_timeout, 0);
        chk("rst_rd_count", rd_count, 0);
        enable = 3'b001; in = 3'b001; rd_ch = 2'd0;
        for (int k = 1; k <= 200; k++) begin
            cyc();
            if (k == 99)  chk("t1_no_early_pulse", timeout[0], 0);
            if (k == 100 || k == 200) begin
                chk("t1_pulse", timeout[0], 1);
                chk("t1_any", any_timeout, 1);
                chk("t1_rd_before_wrap", rd_count, 99);
            end
            if (k == 101) begin
                chk("t1_pulse_single", timeout[0], 0);
                chk("t1_count_wrapped", rd_count, 0);
            end
        end

        // Table-driven one-shot sequence.
        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].rst; enable = tbl[i].en; in = tbl[i].inp; ch_clr = tbl[i].clr;
            cfg_we = tbl[i].we; cfg_ch = tbl[i].ch; cfg_term = tbl[i].term;
            cfg_mode = tbl[i].mode; rd_ch = tbl[i].rd;
            cyc();
            chk($sformatf("tbl%0d_timeout", i), timeout, tbl[i].to);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].dn);
            chk($sformatf("tbl%0d_any", i), any_timeout, |tbl[i].to);
            chk($sformatf("tbl%0d_rd", i), rd_count, tbl[i].rdc);
        end

        // Enable low freezes the count without clearing it.
        do_reset();
        enable = 3'b100; in = 3'b100; rd_ch = 2'd2;
        repeat (50) cyc();
        enable = 3'b000;
        repeat (20) cyc();
        chk("t3_frozen_count", rd_count, 50);
        chk("t3_no_pulse", timeout, 0);
        enable = 3'b100;
        for (int k = 1; k <= 50; k++) begin
            cyc();
            if (k == 49) chk("t3_no_early", timeout[2], 0);
            if (k == 50) chk("t3_pulse", timeout[2], 1);
        end

        // Config write beats clear and a terminal tick in the same cycle.
        do_reset();
        enable = 3'b001; in = 3'b001; rd_ch = 2'd0;
        repeat (99) cyc();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_term = 7'd5; cfg_mode = 1'b0; ch_clr = 3'b001;
        cyc();
        chk("t4_cfg_wins_timeout", timeout[0], 0);
        chk("t4_cfg_wins_any", any_timeout, 0);
        cfg_we = 1'b0; ch_clr = 3'b000;
        cyc();
        chk("t4_count_cleared", rd_count, 0);
        for (int k = 2; k <= 6; k++) begin
            cyc();
            if (k == 6) chk("t4_new_term_pulse", timeout[0], 1);
            else        chk("t4_new_term_quiet", timeout[0], 0);
        end
        repeat (2) cyc();
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_term = 7'd0; cfg_mode = 1'b1;
        cyc();
        cfg_we = 1'b0;
        cyc();
        chk("t4_oob_cfg_count", rd_count, 3);
        chk("t4_oob_cfg_done", done, 0);

        // term=0 pulses every tick; readback sweep; full-range term; mid-count reset.
        do_reset();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_term = 7'd0; cfg_mode = 1'b0;
        cyc();
        cfg_we = 1'b0; enable = 3'b001; in = 3'b001;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("t5_term0_pulse", timeout[0], 1);
        end
        enable = 3'b110; in = 3'b110;
        repeat (3) cyc();
        enable = 3'b100;
        repeat (4) cyc();
        enable = 3'b000;
        for (int r = 0; r < 4; r++) begin
            logic [W-1:0] want[4];
            want[0] = 7'd0; want[1] = 7'd3; want[2] = 7'd7; want[3] = 7'd0;
            rd_ch = CHW'(r);
            cyc();
            chk("t5_rd_sweep", rd_count, want[r]);
        end
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_term = 7'd127; cfg_mode = 1'b0;
        cyc();
        cfg_we = 1'b0; enable = 3'b100; in = 3'b100; rd_ch = 2'd2;
        for (int k = 1; k <= 128; k++) begin
            cyc();
            if (k == 127) begin
                chk("t5_full_quiet", timeout[2], 0);
                chk("t5_full_rd", rd_count, 126);
            end
            if (k == 128) begin
                chk("t5_full_pulse", timeout[2], 1);
                chk("t5_full_rd_top", rd_count, 127);
            end
        end
        enable = 3'b011; in = 3'b011; rd_ch = 2'd1;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t5_rst_timeout", timeout, 0);
        chk("t5_rst_any", any_timeout, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_rd", rd_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
